// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int PKG_XLEN   = 64;
  localparam int PKG_INST_W = 32;

  // addi x0, x0, 0: harmless filler carried by fault entries
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DROP,
    HALT
  } fetch_state_e;

  typedef struct packed {
    logic [PKG_XLEN-1:0]   pc;
    logic [PKG_INST_W-1:0] inst;
    logic                  fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory and decode handshakes seen by the fetch stage.
interface fetch_stage_if #(
  parameter int XLEN   = 64,
  parameter int INST_W = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              imem_resp_err;
  logic              decode_o_valid;
  logic              decode_i_ready;
  logic [XLEN-1:0]   decode_o_pc;
  logic [INST_W-1:0] decode_o_inst;
  logic              decode_o_fault;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    output decode_o_valid, decode_o_pc, decode_o_inst, decode_o_fault,
    input  decode_i_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    input  decode_o_valid, decode_o_pc, decode_o_inst, decode_o_fault,
    output decode_i_ready
  );
endinterface

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready holding register; flush drops the entry.
module fetch_out_buf #(
  parameter int W = 97
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         fill,
  input  logic [W-1:0] fill_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         vld_p1;
  logic [W-1:0] data_p1;

  // ---- stage p1: held entry ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      if (flush)      vld_p1 <= 1'b0;
      else if (fill)  vld_p1 <= 1'b1;
      else if (ready) vld_p1 <= 1'b0;
      if (fill && !flush) data_p1 <= fill_data;
    end
  end

  assign valid = vld_p1;
  assign data  = data_p1;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, redirect squash, and
// a one-entry buffer toward decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                XLEN     = PKG_XLEN,
  parameter int                INST_W   = PKG_INST_W,
  parameter logic [INST_W-1:0] NOP_INST = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_i_pc,
  input  logic            execute_i_need_jump,
  output logic [XLEN-1:0] fetch_o_pre_pc,
  fetch_stage_if.master   bus
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] cap_pc_p1;
  fetch_entry_t    fill_entry, buf_entry;
  logic            fill, buf_valid, room, aligned, req_valid, accept;

  // The buffer is empty or being popped, so a response landing later has a slot.
  assign room    = !buf_valid || bus.decode_i_ready;
  assign aligned = (fetch_i_pc[1:0] == 2'b00);

  // ---- stage p1: FSM state and captured request PC ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= REQ;
      cap_pc_p1 <= '0;
    end else begin
      state <= state_n;
      if (accept) cap_pc_p1 <= fetch_i_pc;
    end
  end

  always_comb begin
    state_n        = state;
    req_valid      = 1'b0;
    accept         = 1'b0;
    fill           = 1'b0;
    fetch_o_pre_pc = fetch_i_pc;
    fill_entry     = '{pc: cap_pc_p1, inst: bus.imem_resp_data, fault: bus.imem_resp_err};
    case (state)
      REQ: begin
        if (!execute_i_need_jump && room) begin
          if (aligned) begin
            req_valid = 1'b1;
            if (bus.imem_req_ready) begin
              accept         = 1'b1;
              fetch_o_pre_pc = fetch_i_pc + PC_STEP;
              state_n        = WAIT;
            end
          end else begin
            fill       = 1'b1;
            fill_entry = '{pc: fetch_i_pc, inst: NOP_INST, fault: 1'b1};
            state_n    = HALT;
          end
        end
      end
      WAIT: begin
        if (bus.imem_resp_valid) begin
          if (execute_i_need_jump) state_n = REQ;
          else begin
            fill    = 1'b1;
            state_n = bus.imem_resp_err ? HALT : REQ;
          end
        end else if (execute_i_need_jump) begin
          state_n = DROP;
        end
      end
      DROP: if (bus.imem_resp_valid) state_n = REQ;
      HALT: if (execute_i_need_jump) state_n = REQ;
      default: state_n = REQ;
    endcase
  end

  fetch_out_buf #(
    .W($bits(fetch_entry_t))
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (execute_i_need_jump),
    .fill     (fill),
    .fill_data(fill_entry),
    .ready    (bus.decode_i_ready),
    .valid    (buf_valid),
    .data     (buf_entry)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_i_pc;
  assign bus.decode_o_valid = buf_valid;
  assign bus.decode_o_pc    = buf_entry.pc;
  assign bus.decode_o_inst  = buf_entry.inst;
  assign bus.decode_o_fault = buf_entry.fault;

endmodule
